seq_div32_16: RTL and testbench

- Iterative radix-2 restoring divider that takes a 2*DW-bit dividend and a DW-bit divisor; the inverse operation of the 16-bit multiplier datapath.
- Used to reconstruct an operand from an (exact or approximate) product. This lets the error-characterisation flow measure how far an approximate-compressor product drifts from the operand that produced it.
- Sits between the multiplier output register and the error-statistics logic.
- Valid/ready on both sides; one division in flight at a time.

---
 rtl/seq_div32_16.sv | 118 +++++++++++
 tb/tb_seq_div32_16.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div32_16.sv
// seq_div32_16: iterative radix-2 restoring divider, 2*DW-bit dividend by DW-bit divisor.
// One quotient bit per cycle, MSB first; one division in flight with valid/ready on both sides.
// A zero divisor skips the iteration and returns an all-ones quotient with the dividend's low half
// as the remainder.
`timescale 1ns/1ps

module seq_div32_16 #(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   quotient,
    output logic [DW-1:0]     remainder,
    output logic              div_by_zero
);

    // state | meaning
    // IDLE  | waiting for an operation, in_ready=1
    // CALC  | 2*DW restoring steps, one quotient bit per cycle
    // DONE  | result held on the outputs, out_valid=1
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(2*DW);

    state_t              state, state_nxt;
    logic [2*DW-1:0]     dvd_sh;     // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [DW-1:0]       dvs;
    logic [DW-1:0]       rem_acc;    // partial remainder; always < divisor, so its top bit never needs storing
    logic [CW-1:0]       step;
    logic [DW:0]         trial;
    logic [DW:0]         diff;
    logic                q_bit;
    logic [DW-1:0]       rem_nxt;
    logic                last_step;

    // One restoring step: the borrow out of the DW+1-bit subtraction decides the quotient bit.
    always_comb begin
        trial     = {rem_acc, dvd_sh[2*DW-1]};
        diff      = trial - {1'b0, dvs};
        q_bit     = ~diff[DW];
        rem_nxt   = q_bit ? diff[DW-1:0] : trial[DW-1:0];
        last_step = (step == CW'(2*DW-1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs, decoded from the registered state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, load the result registers on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_sh      <= '0;
            dvs         <= '0;
            rem_acc     <= '0;
            step        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_sh  <= dividend;
                        dvs     <= divisor;
                        rem_acc <= '0;
                        step    <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[DW-1:0];
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd_sh  <= {dvd_sh[2*DW-2:0], q_bit};
                    rem_acc <= rem_nxt;
                    step    <= step + 1'b1;
                    if (last_step) begin
                        quotient    <= {dvd_sh[2*DW-2:0], q_bit};
                        remainder   <= rem_nxt;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div32_16.sv
// tb_seq_div32_16: directed cases plus random operations against an arithmetic reference model.
`timescale 1ns/1ps

module tb_seq_div32_16;

    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   dividend;
    logic [DW-1:0]     divisor;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   quotient;
    logic [DW-1:0]     remainder;
    logic              div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_div32_16 #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, with the zero-divisor convention.
    task automatic ref_div(input logic [31:0] a, input logic [15:0] b,
                           output logic [31:0] q, output logic [15:0] r, output logic z);
        logic [31:0] rr;
        if (b == 16'd0) begin
            q = 32'hFFFF_FFFF;
            r = a[15:0];
            z = 1'b1;
        end else begin
            q  = a / {16'd0, b};
            rr = a % {16'd0, b};
            r  = rr[15:0];
            z  = 1'b0;
        end
    endtask

    // One full transaction: accept, wait for the result, hold it, hand it off.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int hold, input bit junk);
        logic [31:0] eq, q0;
        logic [15:0] er, r0;
        logic        ez, z0;
        logic [63:0] recon;
        int          lat, ready_hi, unstable;

        ref_div(a, b, eq, er, ez);

        lat = 0;
        while (!in_ready && lat < 100) begin
            tick;
            lat++;
        end
        chk("pre_ready", in_ready, 1);

        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick;
        if (!junk) in_valid = 1'b0;

        lat      = 0;
        ready_hi = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_hi++;
            if (junk) begin
                dividend = $urandom;
                divisor  = 16'($urandom);
            end
            tick;
            lat++;
        end
        if (in_ready) ready_hi++;
        chk("latency", lat, (b == 16'd0) ? 0 : 32);
        chk("busy_ready", ready_hi, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        if (b != 16'd0) begin
            recon = 64'(quotient) * 64'(b) + 64'(remainder);
            chk("identity", recon, 64'(a));
            chk("rem_lt_div", remainder < b, 1);
        end

        if (hold > 0) begin
            q0 = quotient;
            r0 = remainder;
            z0 = div_by_zero;
            unstable = 0;
            repeat (hold) begin
                if (junk) begin
                    dividend = $urandom;
                    divisor  = 16'($urandom);
                end
                tick;
                if (!out_valid || quotient !== q0 || remainder !== r0 || div_by_zero !== z0)
                    unstable++;
            end
            chk("hold_stable", unstable, 0);
        end

        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("back_idle", {in_ready, out_valid}, 2'b10);
        chk("kept_quotient", quotient, eq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        logic [31:0] a;
        logic [15:0] b;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) tick;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);

        run_op(32'hFFFE_0001, 16'hFFFF, 0, 1'b0);
        run_op(32'd100, 16'd7, 5, 1'b0);
        run_op(32'h1234_5678, 16'd0, 0, 1'b0);
        run_op(32'h1234_5678, 16'd1, 0, 1'b0);

        // Abort an operation with reset at accept+10.
        dividend = 32'hFFFF_FFFF;
        divisor  = 16'd3;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        seen = 0;
        repeat (40) begin
            tick;
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        run_op(32'd9, 16'd3, 0, 1'b0);

        run_op(32'hABCD_EF01, 16'h1234, 3, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 16'd1;
                1: b = 16'hFFFF;
                2: begin
                    b = 16'($urandom_range(1, 65535));
                    a = $urandom_range(0, 32'(b) - 1);
                end
                3: b = 16'($urandom_range(0, 7));
                default: b = 16'($urandom);
            endcase
            run_op(a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
